tt_um_alarm_vector_driver: RTL and testbench



---
 rtl/tt_um_alarm_vector_driver.sv | 129 ++++++++++++
 tb/tb_tt_um_alarm_vector_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_alarm_vector_driver.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_alarm_vector_driver
// Purpose  : Drives 6-bit vectors into an external alarm tile and tallies
//            how many assert its active-low indicator, plus their checksum.
// Revision : 1.0
// ============================================================================
module tt_um_alarm_vector_driver #(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] c_settle_last = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_vec, w_vec_nxt;
    logic [7:0]  r_timer, w_timer_nxt;
    logic [6:0]  r_hit_count, w_hit_count_nxt;
    logic [7:0]  r_checksum, w_checksum_nxt;
    logic        r_done, w_done_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_mode, w_mode_nxt;
    logic        r_start_prev;
    logic        r_resp_meta, r_resp_q;
    logic        w_edge;

    // Only the start edge, mode/select, vector and response bit are consumed
    logic w_unused_inputs;
    assign w_unused_inputs = &{1'b0, ena, uio_in[7], uio_in[5:0]};

    assign w_edge = ui_in[0] & ~r_start_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vec        <= 6'd0;
            r_timer      <= 8'd0;
            r_hit_count  <= 7'd0;
            r_checksum   <= 8'd0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_mode       <= 1'b0;
            r_start_prev <= 1'b0;
            r_resp_meta  <= 1'b1;
            r_resp_q     <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_vec        <= w_vec_nxt;
            r_timer      <= w_timer_nxt;
            r_hit_count  <= w_hit_count_nxt;
            r_checksum   <= w_checksum_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= w_busy_nxt;
            r_mode       <= w_mode_nxt;
            r_start_prev <= ui_in[0];
            r_resp_meta  <= uio_in[6];
            r_resp_q     <= r_resp_meta;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_vec_nxt       = r_vec;
        w_timer_nxt     = r_timer;
        w_hit_count_nxt = r_hit_count;
        w_checksum_nxt  = r_checksum;
        w_done_nxt      = r_done;
        w_busy_nxt      = r_busy;
        w_mode_nxt      = r_mode;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_edge) begin
                    w_state_nxt     = S_DRIVE;
                    w_mode_nxt      = ui_in[1];
                    w_vec_nxt       = ui_in[1] ? ui_in[7:2] : 6'd0;
                    w_timer_nxt     = 8'd0;
                    w_hit_count_nxt = 7'd0;
                    w_checksum_nxt  = 8'd0;
                    w_done_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                end
            end
            S_DRIVE: begin
                w_timer_nxt = r_timer + 8'd1;
                if (r_timer == c_settle_last) begin
                    // Indicator is active-low: a low synchronized response is a hit
                    if (!r_resp_q) begin
                        if (r_hit_count != 7'h7F) begin
                            w_hit_count_nxt = r_hit_count + 7'd1;
                        end
                        w_checksum_nxt = r_checksum + {2'b00, r_vec};
                    end
                    if (r_mode || (r_vec == 6'd63)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_vec_nxt   = r_vec + 6'd1;
                        w_timer_nxt = 8'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign uo_out  = ui_in[1] ? r_checksum : {r_done, r_hit_count};
    assign uio_out = {r_busy, 1'b0, (r_state == S_IDLE) ? 6'd0 : r_vec};
    assign uio_oe  = 8'hBF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_alarm_vector_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_alarm_vector_driver
// Purpose  : Directed self-checking bench with a modelled alarm tile response.
// Revision : 1.0
// ============================================================================
module tb_tt_um_alarm_vector_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] noise;
    int         rmode;
    int         total = 0;
    int         bad   = 0;
    logic [15:0] sb[$];

    tt_um_alarm_vector_driver #(.SETTLE(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Alarm tile model: 0 never asserts, 1 always asserts, 2 asserts for vec[5]=1
    function automatic logic resp_bit(input int rm, input logic [5:0] v);
        case (rm)
            0:       return 1'b1;
            1:       return 1'b0;
            default: return ~v[5];
        endcase
    endfunction

    always_comb begin
        uio_in = {noise[7], resp_bit(rmode, uio_out[5:0]), noise[5:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit single, input logic [5:0] v, input int rm, input bit hold);
        int          n;
        logic [6:0]  cnt;
        logic [7:0]  sum;
        logic [5:0]  vv;
        logic [15:0] e;
        rmode = rm;
        cnt   = 7'd0;
        sum   = 8'd0;
        n     = single ? 1 : 64;
        for (int k = 0; k < n; k++) begin
            vv = single ? v : 6'(k);
            if (!resp_bit(rm, vv)) begin
                cnt = cnt + 7'd1;
                sum = sum + {2'b00, vv};
            end
        end
        sb.push_back({1'b1, cnt, sum});
        ui_in = {v, single, 1'b1};
        tick();
        if (!hold) ui_in[0] = 1'b0;
        for (int j = 0; j < n * 4; j++) begin
            vv = single ? v : 6'(j / 4);
            chk("vec", {2'b00, uio_out[5:0]}, {2'b00, vv});
            chk("busy", {7'd0, uio_out[7]}, 8'd1);
            if (hold && j == 100) ui_in[0] = 1'b0;
            if (hold && j == 101) ui_in[0] = 1'b1;
            tick();
        end
        e = sb.pop_front();
        ui_in[1] = 1'b0;
        #1;
        chk("done_disp", uo_out, e[15:8]);
        chk("busy_end", {uio_out[7], uio_out[6], uio_out[5:0]}, {2'b00, vv});
        ui_in[1] = 1'b1;
        #1;
        chk("checksum", uo_out, e[7:0]);
        ui_in[1] = 1'b0;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        ena   = 1'b1;
        rmode = 0;
        noise = 8'($urandom);
        ui_in = 8'($urandom);
        tick();
        ui_in = 8'($urandom);
        noise = 8'($urandom);
        tick();
        ui_in[1] = 1'b0;
        #1;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hBF);
        ui_in[1] = 1'b1;
        #1;
        chk("rst_csum", uo_out, 8'h00);

        ui_in = 8'h00;
        rst_n = 1'b1;
        tick();

        run(1'b0, 6'd0, 0, 1'b0);
        run(1'b0, 6'd0, 1, 1'b0);
        run(1'b0, 6'd0, 2, 1'b1);
        // Start still held high in DONE: no new edge, results must persist
        repeat (5) tick();
        chk("hold_disp", uo_out, 8'hA0);
        chk("hold_busy", {7'd0, uio_out[7]}, 8'd0);
        ui_in[0] = 1'b0;
        tick();
        run(1'b0, 6'd0, 0, 1'b0);
        tick();
        run(1'b1, 6'h2A, 1, 1'b0);
        tick();

        // Reset in the middle of a sweep
        rmode = 1;
        ui_in = 8'h01;
        tick();
        ui_in[0] = 1'b0;
        repeat (50) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_uo", uo_out, 8'h00);
        chk("mid_rst_uio", uio_out, 8'h00);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            tick();
            seen = seen | uo_out[7] | uio_out[7];
        end
        chk("no_done_after_rst", {7'd0, seen}, 8'd0);
        chk("sb_empty", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
